// File: rtl/bp_fe_lce_resp_sched.sv
// Arbitrates the FE req and cmd LCE engines onto the single LCE->CCE response channel.
// Fixed priority to the req engine, with a bounded wait for the cmd engine, into a 1-entry output buffer.
module bp_fe_lce_resp_sched
  #(parameter int resp_width_p   = 64
  , parameter int starve_limit_p = 4
  )
  (input  logic                    clk_i
  , input  logic                    reset_i

  , input  logic [resp_width_p-1:0] req_resp_i
  , input  logic                    req_resp_v_i
  , output logic                    req_resp_yumi_o

  , input  logic [resp_width_p-1:0] cmd_resp_i
  , input  logic                    cmd_resp_v_i
  , output logic                    cmd_resp_yumi_o

  , output logic [resp_width_p-1:0] lce_resp_o
  , output logic                    lce_resp_v_o
  , input  logic                    lce_resp_ready_i
  , output logic                    lce_resp_src_o

  , output logic                    starved_o
  );

  localparam int cnt_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_w_lp-1:0] limit_lp = cnt_w_lp'(starve_limit_p);

  logic                    full_q, full_d;
  logic [resp_width_p-1:0] data_q, data_d;
  logic                    src_q, src_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;

  logic load_en, at_limit, grant_req, grant_cmd, load, xfer;

  assign xfer      = full_q & lce_resp_ready_i;
  assign load_en   = (~full_q | xfer) & ~reset_i;
  assign at_limit  = (cnt_q == limit_lp);

  // The cmd engine wins a contested slot only once it has waited starve_limit_p grants.
  assign grant_cmd = load_en & cmd_resp_v_i & (~req_resp_v_i | at_limit);
  assign grant_req = load_en & req_resp_v_i & ~(cmd_resp_v_i & at_limit);
  assign load      = grant_req | grant_cmd;

  assign req_resp_yumi_o = grant_req;
  assign cmd_resp_yumi_o = grant_cmd;
  assign starved_o       = load_en & req_resp_v_i & cmd_resp_v_i & at_limit;

  assign lce_resp_o      = data_q;
  assign lce_resp_v_o    = full_q;
  assign lce_resp_src_o  = src_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    src_d  = src_q;
    cnt_d  = cnt_q;
    if (load) begin
      full_d = 1'b1;
      data_d = grant_cmd ? cmd_resp_i : req_resp_i;
      src_d  = grant_cmd;
      if (grant_cmd | ~cmd_resp_v_i)
        cnt_d = '0;
      else if (!at_limit)
        cnt_d = cnt_q + cnt_w_lp'(1);
    end else if (xfer) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      data_q <= '0;
      src_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      src_q  <= src_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
